// File: rtl/sm_tick_gen_pkg.sv
// Shared definitions for the tick/clock-enable generator: default sizing
// and the bundle of asynchronous control levels carried through the synchronizers.
package sm_tick_gen_pkg;

    localparam int DEFAULT_CHANNELS    = 2;
    localparam int DEFAULT_CNT_W       = 16;
    localparam int DEFAULT_SYNC_STAGES = 2;

    typedef struct packed {
        logic enable;
        logic stepMode;
        logic stepReq;
    } ctrl_t;

endpackage

// File: rtl/sm_tick_gen_if.sv
// Control/strobe bundle between the board-level controls and the tick generator.
interface sm_tick_gen_if
    import sm_tick_gen_pkg::*;
#(
    parameter int CHANNELS = DEFAULT_CHANNELS,
    parameter int CNT_W    = DEFAULT_CNT_W
) ();

    logic [CHANNELS*CNT_W-1:0] divide;
    logic [CHANNELS-1:0]       enable;
    logic [CHANNELS-1:0]       stepMode;
    logic [CHANNELS-1:0]       stepReq;
    logic [CHANNELS-1:0]       stepAck;
    logic [CHANNELS-1:0]       tick;
    logic [CHANNELS-1:0]       clkOut;

    modport master (
        output divide, enable, stepMode, stepReq,
        input  stepAck, tick, clkOut
    );

    modport slave (
        input  divide, enable, stepMode, stepReq,
        output stepAck, tick, clkOut
    );

endinterface

// File: rtl/sm_tick_channel.sv
// One tick channel: input synchronizers, divide-by-(divide+1) counter,
// IDLE/STEP/RUN mode selection and the 4-phase single-step handshake.
module sm_tick_channel
    import sm_tick_gen_pkg::*;
#(
    parameter int CNT_W       = DEFAULT_CNT_W,
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CNT_W-1:0] divide,
    input  logic             enable,
    input  logic             stepMode,
    input  logic             stepReq,
    output logic             stepAck,
    output logic             tick,
    output logic             clkOut
);

    typedef enum logic [1:0] {
        MODE_IDLE = 2'd0,
        MODE_STEP = 2'd1,
        MODE_RUN  = 2'd2
    } mode_e;

    // Raw levels are captured once on entry and then cross SYNC_STAGES more flops.
    ctrl_t [SYNC_STAGES:0] sync_r;
    ctrl_t                 raw_s;
    ctrl_t                 ctrl_s;
    mode_e                 mode_s;

    logic [CNT_W-1:0] cnt_r, cntNext_s;
    logic [CNT_W-1:0] divReg_r, divRegNext_s;
    logic             tick_r, tickNext_s;
    logic             clkOut_r, clkOutNext_s;
    logic             stepAck_r, stepAckNext_s;

    assign raw_s  = {enable, stepMode, stepReq};
    assign ctrl_s = sync_r[SYNC_STAGES];

    // Synchronizer shift chain for the asynchronous control levels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= '0;
        end else begin
            sync_r[0] <= raw_s;
            for (int k = 1; k <= SYNC_STAGES; k++) begin
                sync_r[k] <= sync_r[k-1];
            end
        end
    end

    // Mode decode: disable beats step mode, step mode beats free-run.
    always_comb begin
        mode_s = MODE_IDLE;
        if (!ctrl_s.enable) begin
            mode_s = MODE_IDLE;
        end else if (ctrl_s.stepMode) begin
            mode_s = MODE_STEP;
        end else begin
            mode_s = MODE_RUN;
        end
    end

    // Next-state logic for counter, latched period, strobe, clock and handshake.
    always_comb begin
        cntNext_s     = cnt_r;
        divRegNext_s  = divReg_r;
        tickNext_s    = 1'b0;
        clkOutNext_s  = clkOut_r;
        stepAckNext_s = stepAck_r;

        // The ack release is honoured in every mode so a handshake never stalls.
        if (!ctrl_s.stepReq) begin
            stepAckNext_s = 1'b0;
        end else begin
            stepAckNext_s = stepAck_r;
        end

        case (mode_s)
            MODE_IDLE: begin
                cntNext_s    = '0;
                divRegNext_s = divide;
            end
            MODE_STEP: begin
                cntNext_s    = '0;
                divRegNext_s = divide;
                if (ctrl_s.stepReq && !stepAck_r) begin
                    tickNext_s    = 1'b1;
                    clkOutNext_s  = ~clkOut_r;
                    stepAckNext_s = 1'b1;
                end else begin
                    tickNext_s = 1'b0;
                end
            end
            MODE_RUN: begin
                if (cnt_r == divReg_r) begin
                    tickNext_s   = 1'b1;
                    clkOutNext_s = ~clkOut_r;
                    cntNext_s    = '0;
                    divRegNext_s = divide;
                end else begin
                    cntNext_s  = cnt_r + CNT_W'(1'b1);
                    tickNext_s = 1'b0;
                end
            end
            default: begin
                cntNext_s    = '0;
                divRegNext_s = divide;
            end
        endcase
    end

    // Channel state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r     <= '0;
            divReg_r  <= '0;
            tick_r    <= 1'b0;
            clkOut_r  <= 1'b0;
            stepAck_r <= 1'b0;
        end else begin
            cnt_r     <= cntNext_s;
            divReg_r  <= divRegNext_s;
            tick_r    <= tickNext_s;
            clkOut_r  <= clkOutNext_s;
            stepAck_r <= stepAckNext_s;
        end
    end

    assign tick    = tick_r;
    assign clkOut  = clkOut_r;
    assign stepAck = stepAck_r;

endmodule

// File: rtl/sm_tick_gen.sv
// Multi-channel programmable tick / clock-enable generator: slices the divide
// bus per channel and gathers the per-channel strobes back onto the bundle.
module sm_tick_gen
    import sm_tick_gen_pkg::*;
#(
    parameter int CHANNELS    = DEFAULT_CHANNELS,
    parameter int CNT_W       = DEFAULT_CNT_W,
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
    input logic         clk,
    input logic         rst_n,
    sm_tick_gen_if.slave bus
);

    logic [CHANNELS-1:0] stepAck_s;
    logic [CHANNELS-1:0] tick_s;
    logic [CHANNELS-1:0] clkOut_s;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        sm_tick_channel #(
            .CNT_W       (CNT_W),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .divide   (bus.divide[i*CNT_W +: CNT_W]),
            .enable   (bus.enable[i]),
            .stepMode (bus.stepMode[i]),
            .stepReq  (bus.stepReq[i]),
            .stepAck  (stepAck_s[i]),
            .tick     (tick_s[i]),
            .clkOut   (clkOut_s[i])
        );
    end

    assign bus.stepAck = stepAck_s;
    assign bus.tick    = tick_s;
    assign bus.clkOut  = clkOut_s;

endmodule

// File: tb/tb_sm_tick_gen.sv
// Randomized scoreboard bench for sm_tick_gen: a deadline-based reference model
// predicts tick and ack events, a monitor pops and compares them as the DUT emits them.
module tb_sm_tick_gen;

    localparam int CH  = 2;
    localparam int W   = 8;
    localparam int SS  = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    sm_tick_gen_if #(.CHANNELS(CH), .CNT_W(W)) bus ();

    sm_tick_gen #(
        .CHANNELS    (CH),
        .CNT_W       (W),
        .SYNC_STAGES (SS)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int   cyc;
        logic lvl;
    } ev_t;

    ev_t tickQ [CH][$];
    ev_t ackQ  [CH][$];

    int cyc   = 0;
    int nVec  = 0;
    int nFail = 0;

    // reference model state: raw-input history, latched period, next deadline
    logic [SS:0] hEn [CH];
    logic [SS:0] hSm [CH];
    logic [SS:0] hRq [CH];
    int          divL     [CH];
    int          due      [CH];
    int          prevMode [CH];
    logic        clkM     [CH];
    logic        ackM     [CH];
    logic        prevAck  [CH];

    task automatic chk(input string nm, input int c, input int got, input int exp);
        nVec++;
        if (got != exp) begin
            nFail++;
            $display("FAIL %s ch%0d: got %0d, expected %0d (cycle %0d)", nm, c, got, exp, cyc);
        end
    endtask

    // Reference model: ticks are scheduled as absolute deadlines, not counted.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            for (int c = 0; c < CH; c++) begin
                if (!rst_n) begin
                    hEn[c] = '0; hSm[c] = '0; hRq[c] = '0;
                    divL[c] = 0; due[c] = 0; prevMode[c] = 0;
                    clkM[c] = 1'b0; ackM[c] = 1'b0;
                    tickQ[c].delete();
                    ackQ[c].delete();
                end else begin
                    logic e, m, r, tk, na;
                    int   mode, divNow;
                    e = hEn[c][SS]; m = hSm[c][SS]; r = hRq[c][SS];
                    divNow = int'(bus.divide[c*W +: W]);
                    mode = !e ? 0 : (m ? 1 : 2);
                    tk = 1'b0;
                    na = r ? ackM[c] : 1'b0;
                    if (mode == 2) begin
                        if (prevMode[c] != 2) due[c] = cyc + divL[c];
                        if (cyc == due[c]) begin
                            tk = 1'b1;
                            divL[c] = divNow;
                            due[c] = cyc + divNow + 1;
                        end
                    end else begin
                        divL[c] = divNow;
                        if (mode == 1 && r && !ackM[c]) begin
                            tk = 1'b1;
                            na = 1'b1;
                        end
                    end
                    if (tk) begin
                        clkM[c] = ~clkM[c];
                        tickQ[c].push_back('{cyc, clkM[c]});
                    end
                    if (na != ackM[c]) begin
                        ackQ[c].push_back('{cyc, na});
                        ackM[c] = na;
                    end
                    prevMode[c] = mode;
                    hEn[c] = {hEn[c][SS-1:0], bus.enable[c]};
                    hSm[c] = {hSm[c][SS-1:0], bus.stepMode[c]};
                    hRq[c] = {hRq[c][SS-1:0], bus.stepReq[c]};
                end
            end
        end
    end

    // Monitor: compare every DUT tick and ack transition against the queued expectation.
    initial begin
        for (int c = 0; c < CH; c++) prevAck[c] = 1'b0;
        forever begin
            @(negedge clk);
            for (int c = 0; c < CH; c++) begin
                if (!rst_n) begin
                    prevAck[c] = 1'b0;
                end else begin
                    ev_t ev;
                    if (bus.tick[c]) begin
                        if (tickQ[c].size() == 0) begin
                            chk("unexpected_tick", c, 1, 0);
                        end else begin
                            ev = tickQ[c].pop_front();
                            chk("tick_cycle", c, cyc, ev.cyc);
                            chk("clkOut_level", c, int'(bus.clkOut[c]), int'(ev.lvl));
                        end
                    end
                    while (tickQ[c].size() > 0 && tickQ[c][0].cyc < cyc) begin
                        ev = tickQ[c].pop_front();
                        chk("missed_tick_at", c, -1, ev.cyc);
                    end
                    if (bus.stepAck[c] != prevAck[c]) begin
                        if (ackQ[c].size() == 0) begin
                            chk("unexpected_ack_edge", c, int'(bus.stepAck[c]), int'(prevAck[c]));
                        end else begin
                            ev = ackQ[c].pop_front();
                            chk("ack_cycle", c, cyc, ev.cyc);
                            chk("ack_level", c, int'(bus.stepAck[c]), int'(ev.lvl));
                        end
                    end
                    while (ackQ[c].size() > 0 && ackQ[c][0].cyc < cyc) begin
                        ev = ackQ[c].pop_front();
                        chk("missed_ack_edge_at", c, -1, ev.cyc);
                    end
                    prevAck[c] = bus.stepAck[c];
                end
            end
        end
    end

    task automatic check_outputs_zero(input string tag);
        for (int c = 0; c < CH; c++) begin
            chk({tag, "_tick"},    c, int'(bus.tick[c]),    0);
            chk({tag, "_clkOut"},  c, int'(bus.clkOut[c]),  0);
            chk({tag, "_stepAck"}, c, int'(bus.stepAck[c]), 0);
        end
    endtask

    task automatic jitter_inputs(input int firstCh);
        for (int c = firstCh; c < CH; c++) begin
            if ($urandom % 8 == 0) bus.stepReq[c] = ~bus.stepReq[c];
            if ($urandom % 16 == 0) bus.divide[c*W +: W] = W'($urandom_range(0, 6));
        end
    endtask

    // Stimulus: random mode/divide segments, a mid-run reset and a full-range period.
    initial begin
        bus.divide   = '0;
        bus.enable   = '0;
        bus.stepMode = '0;
        bus.stepReq  = '0;
        rst_n        = 1'b0;
        repeat (2) @(negedge clk);
        check_outputs_zero("reset");
        rst_n = 1'b1;

        for (int seg = 0; seg < 70; seg++) begin
            @(negedge clk);
            for (int c = 0; c < CH; c++) begin
                bus.enable[c]          = ($urandom % 5) != 0;
                bus.stepMode[c]        = ($urandom % 3) == 0;
                bus.divide[c*W +: W]   = W'($urandom_range(0, 6));
            end
            if (seg == 25) begin
                #2 rst_n = 1'b0;
                #1 check_outputs_zero("async_reset");
                @(negedge clk);
                rst_n = 1'b1;
            end
            repeat ($urandom_range(1, 60)) begin
                @(negedge clk);
                jitter_inputs(0);
            end
        end

        // ch0 free-runs at the widest period while ch1 keeps being exercised
        @(negedge clk);
        bus.enable[0]        = 1'b1;
        bus.stepMode[0]      = 1'b0;
        bus.divide[0 +: W]   = 8'hFF;
        bus.enable[1]        = 1'b1;
        repeat (600) begin
            @(negedge clk);
            jitter_inputs(1);
        end

        @(negedge clk);
        bus.enable  = '0;
        bus.stepReq = '0;
        repeat (12) @(negedge clk);
        for (int c = 0; c < CH; c++) begin
            chk("pending_ticks", c, tickQ[c].size(), 0);
            chk("pending_acks",  c, ackQ[c].size(),  0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
        $finish;
    end

endmodule
